instr_loader: RTL and testbench
===============================

# instr_loader

Program loader that sits directly upstream of the single-cycle core and its instruction memory. It receives a byte stream (header, payload, optional checksum), packs bytes little-endian into 32-bit words, and writes them sequentially into instruction memory starting at address 0. It holds the core in reset until the whole image is written.

## Interface
- ADDR_WIDTH, 10, instruction-memory byte-address width; capacity MAX_WORDS = 2**(ADDR_WIDTH-2)
- DATA_WIDTH, 32, memory word width; fixed at 32, other values unsupported
- CLK  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; re-arms the loader from DONE or ERR
- s_data  in  8  stream byte
- s_valid  in  1  s_data valid
- s_ready  out  1  loader accepts a byte; transfer occurs on s_valid && s_ready
- imem_we  out  1  instruction-memory write strobe, one cycle per word
- imem_addr  out  ADDR_WIDTH  byte address, word aligned
- imem_wd  out  32  write data
- core_rst_n  out  1  active-low reset to the core
- done  out  1  image loaded successfully
- error  out  1  image rejected

## Operation
- Stream format: word count N (2 bytes, LSB first), then N*4 payload bytes (each word LSB first), then 1 checksum byte when configured.
- FSM states: HDR0 -> HDR1 -> DATA -> (CSUM) -> DONE; ERR is reachable from HDR1 and CSUM.
- HDR0: accept the count LSB.
- HDR1: accept the count MSB.
  - N == 0 -> CSUM if configured, else DONE.
  - N > MAX_WORDS -> ERR.
  - Otherwise -> DATA.
- DATA: a 2-bit lane counter places each accepted byte at bits [8*lane+7 : 8*lane].
  - On the 4th lane, the word is written to address word_idx*4 and word_idx increments.
  - After word N-1, go to CSUM if configured, else DONE.
- Only accepted bytes advance the counters. Bubbles on s_valid do not affect the result.
- s_ready = 1 in HDR0, HDR1, DATA and CSUM; 0 in DONE and ERR.
  - s_ready is a combinational decode of state only, with no dependency on s_valid.
- DONE: done = 1, core_rst_n = 1.
- ERR: error = 1, core_rst_n stays 0.
- start in DONE or ERR:
  - Next state is HDR0.
  - done, error and core_rst_n return to 0.
  - word_idx and lane are cleared.
- start in any other state is ignored.

## Timing
- Reset values: state HDR0, imem_we 0, imem_addr 0, imem_wd 0, core_rst_n 0, done 0, error 0, word_idx 0, lane 0, checksum 0. s_ready reads 1 while in HDR0.
- All outputs except s_ready are registered.
- Write latency: byte 4 of a word is accepted at cycle T. At T+1, imem_we = 1 for exactly one cycle, with imem_addr and imem_wd valid.
- The loader never back-pressures a word write. Back-to-back words may produce imem_we in consecutive-word spacing of 4 accepted bytes or more.
- Completion: state enters DONE at T+1, where T is the cycle the last byte is accepted. done and core_rst_n rise at T+2, so the final write always commits before the core leaves reset.
- Asynchronous reset mid-load:
  - Immediate return to the reset values.
  - Any partially assembled word is discarded with no write.
  - core_rst_n drops at once.
- imem_addr wraps are impossible, because N is bounded by MAX_WORDS.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - An 8-bit running sum (mod 256) accumulates over payload bytes only; header bytes are excluded.
  - CSUM accepts one byte: equal to the sum -> DONE, otherwise -> ERR.
  - For N == 0 the expected checksum is 0x00.
- LOADER_CHECKSUM_EN undefined:
  - No CSUM state and no accumulator.
  - The last payload byte leads directly to DONE, and error is only possible from the N > MAX_WORDS check.

## Structure
- Package loader_pkg holds:
  - the state enum (HDR0, HDR1, DATA, CSUM, DONE, ERR);
  - HDR_BYTES = 2, BYTE_W = 8, LANES = 4.
- Sub-module byte_packer holds the lane counter and the 32-bit assembly register. It emits a word_valid pulse together with the assembled word.
- The top level holds the FSM, word_idx, the count/limit check, the checksum and the output registers.

## Test plan
- Load two words: stream 02 00 13 00 50 00 93 00 A0 00 (+96 if checksum configured).
  - Expect a write of 0x00500013 at address 0 and a write of 0x00A00093 at address 4.
  - Expect done = 1 and core_rst_n = 1 two cycles after the last byte.
- Empty image: stream 00 00 (+00).
  - Expect no imem_we pulses, then done = 1.
- Oversize image: with ADDR_WIDTH = 10, stream 01 01 (N = 257 > 256).
  - Expect error = 1, s_ready = 0, core_rst_n = 0, and no writes.
- Bubbles: the same stream as the two-word load with random s_valid gaps.
  - Expect identical writes and identical done behaviour.
- Checksum mismatch (LOADER_CHECKSUM_EN): the two-word load ending in checksum 97.
  - Expect error = 1 and core_rst_n = 0.
  - Then pulse start and send the correct stream: expect done = 1.
- Reset mid-load: assert rst after 6 payload bytes, then reload the two-word image.
  - Expect writes at addresses 0 and 4 only, and no stale data.

Source files
------------

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and constants for the instruction loader
package loader_pkg;

    typedef enum logic [2:0] {
        HDR0 = 3'd0,
        HDR1 = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

    localparam int HDR_BYTES = 2;
    localparam int BYTE_W    = 8;
    localparam int LANES     = 4;

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - packs accepted bytes little-endian into 32-bit words
module byte_packer
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              byte_en,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              word_valid,
    output logic [31:0]       word
);

    logic [1:0]  lane;
    logic [23:0] partial;

    // The fourth byte completes the word in the same cycle it is accepted.
    assign word_valid = byte_en && (lane == 2'(LANES - 1));
    assign word       = {byte_data, partial};

    // Lane counter and storage for the lower three bytes of the word in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane    <= '0;
            partial <= '0;
        end else if (clear) begin
            lane    <= '0;
            partial <= '0;
        end else if (byte_en) begin
            lane <= lane + 2'd1;
            case (lane)
                2'd0:    partial[7:0]   <= byte_data;
                2'd1:    partial[15:8]  <= byte_data;
                2'd2:    partial[23:16] <= byte_data;
                default: partial        <= '0;
            endcase
        end
    end

endmodule

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - streams a program image into instruction memory (optional LOADER_CHECKSUM_EN)
module instr_loader
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wd,
    output logic                  core_rst_n,
    output logic                  done,
    output logic                  error
);

    localparam int         MAX_WORDS = 2 ** (ADDR_WIDTH - 2);
    localparam logic [16:0] MAX_W    = 17'(MAX_WORDS);

    state_t      state;
    logic [7:0]  cnt_lo;
    logic [15:0] count;
    logic [15:0] word_idx;
    logic        accept;
    logic        byte_en;
    logic        restart;
    logic        word_valid;
    logic [31:0] word;
    logic        last_word;
    logic [15:0] hdr_count;
    state_t      after_payload;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum;
    assign after_payload = CSUM;
`else
    assign after_payload = DONE;
`endif

    // Ready is a pure state decode so upstream never sees a valid->ready loop.
    assign s_ready   = (state == HDR0) || (state == HDR1) || (state == DATA) || (state == CSUM);
    assign accept    = s_valid && s_ready;
    assign byte_en   = accept && (state == DATA);
    assign restart   = start && ((state == DONE) || (state == ERR));
    assign last_word = word_valid && ((word_idx + 16'd1) == count);
    assign hdr_count = {s_data, cnt_lo};

    byte_packer u_packer (
        .clk        (CLK),
        .rst_n      (rst),
        .clear      (restart),
        .byte_en    (byte_en),
        .byte_data  (s_data),
        .word_valid (word_valid),
        .word       (word)
    );

    // Loader FSM, word index, checksum and registered memory/status outputs.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state      <= HDR0;
            cnt_lo     <= '0;
            count      <= '0;
            word_idx   <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wd    <= '0;
            core_rst_n <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            imem_we    <= 1'b0;
            // Status trails the state by one cycle so the last write lands before the core runs.
            done       <= (state == DONE) && !restart;
            core_rst_n <= (state == DONE) && !restart;
            error      <= (state == ERR) && !restart;
            case (state)
                HDR0: begin
                    if (accept) begin
                        cnt_lo <= s_data;
                        state  <= HDR1;
                    end
                end
                HDR1: begin
                    if (accept) begin
                        count <= hdr_count;
                        if (hdr_count == 16'd0)
                            state <= after_payload;
                        else if ({1'b0, hdr_count} > MAX_W)
                            state <= ERR;
                        else
                            state <= DATA;
                    end
                end
                DATA: begin
`ifdef LOADER_CHECKSUM_EN
                    if (byte_en)
                        csum <= csum + s_data;
`endif
                    if (word_valid) begin
                        imem_we   <= 1'b1;
                        imem_addr <= {word_idx[ADDR_WIDTH-3:0], 2'b00};
                        imem_wd   <= DATA_WIDTH'(word);
                        word_idx  <= word_idx + 16'd1;
                        if (last_word)
                            state <= after_payload;
                    end
                end
                CSUM: begin
`ifdef LOADER_CHECKSUM_EN
                    if (accept)
                        state <= (s_data == csum) ? DONE : ERR;
`else
                    state <= ERR;
`endif
                end
                DONE, ERR: begin
                    if (start) begin
                        state    <= HDR0;
                        word_idx <= '0;
`ifdef LOADER_CHECKSUM_EN
                        csum     <= '0;
`endif
                    end
                end
                default: state <= HDR0;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - directed self-checking bench for instr_loader
module tb_instr_loader;

    logic        CLK = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wd;
    logic        core_rst_n;
    logic        done;
    logic        error;

    int tests = 0;
    int fails = 0;

    logic [9:0]  wr_addr [0:63];
    logic [31:0] wr_data [0:63];
    int          wr_cnt = 0;
    int          base;

    instr_loader #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
        .CLK        (CLK),
        .rst        (rst),
        .start      (start),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wd    (imem_wd),
        .core_rst_n (core_rst_n),
        .done       (done),
        .error      (error)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (imem_we === 1'b1 && wr_cnt < 64) begin
            wr_addr[wr_cnt] = imem_addr;
            wr_data[wr_cnt] = imem_wd;
            wr_cnt = wr_cnt + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        check("s_ready_before_byte", {31'd0, s_ready}, 32'd1);
        s_valid = 1'b1;
        s_data  = b;
        @(posedge CLK);
        @(negedge CLK);
        s_valid = 1'b0;
        repeat (gap) @(negedge CLK);
    endtask

    task automatic load_two(input int max_gap, input logic [7:0] cs);
        logic [7:0] img [0:9];
        img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
        for (int i = 0; i < 10; i++) begin
`ifdef LOADER_CHECKSUM_EN
            send(img[i], (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
`else
            send(img[i], (i == 9 || max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
`endif
        end
`ifdef LOADER_CHECKSUM_EN
        send(cs, 0);
`endif
    endtask

    task automatic expect_two_done(input string tag);
        check({tag, "_done_T1"}, {31'd0, done}, 32'd0);
        check({tag, "_corerst_T1"}, {31'd0, core_rst_n}, 32'd0);
        @(negedge CLK);
        check({tag, "_done_T2"}, {31'd0, done}, 32'd1);
        check({tag, "_corerst_T2"}, {31'd0, core_rst_n}, 32'd1);
        check({tag, "_sready_done"}, {31'd0, s_ready}, 32'd0);
        check({tag, "_wrcount"}, wr_cnt - base, 32'd2);
        check({tag, "_addr0"}, {22'd0, wr_addr[base]}, 32'd0);
        check({tag, "_data0"}, wr_data[base], 32'h00500013);
        check({tag, "_addr1"}, {22'd0, wr_addr[base + 1]}, 32'd4);
        check({tag, "_data1"}, wr_data[base + 1], 32'h00A00093);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        check("restart_done_low", {31'd0, done}, 32'd0);
        check("restart_error_low", {31'd0, error}, 32'd0);
        check("restart_corerst_low", {31'd0, core_rst_n}, 32'd0);
        check("restart_sready", {31'd0, s_ready}, 32'd1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge CLK);
        check("rst_imem_we", {31'd0, imem_we}, 32'd0);
        check("rst_imem_addr", {22'd0, imem_addr}, 32'd0);
        check("rst_imem_wd", imem_wd, 32'd0);
        check("rst_core_rst_n", {31'd0, core_rst_n}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_s_ready", {31'd0, s_ready}, 32'd1);
        rst = 1'b1;
        @(negedge CLK);

        // Two-word load, no gaps
        base = wr_cnt;
        load_two(0, 8'h96);
        expect_two_done("two");
        pulse_start();

        // Empty image
        base = wr_cnt;
        send(8'h00, 0);
`ifdef LOADER_CHECKSUM_EN
        send(8'h00, 0);
        send(8'h00, 0);
`else
        send(8'h00, 0);
`endif
        check("empty_done_T1", {31'd0, done}, 32'd0);
        @(negedge CLK);
        check("empty_done_T2", {31'd0, done}, 32'd1);
        check("empty_corerst", {31'd0, core_rst_n}, 32'd1);
        check("empty_no_writes", wr_cnt - base, 32'd0);
        pulse_start();

        // Oversize image: N = 257
        base = wr_cnt;
        send(8'h01, 0);
        send(8'h01, 0);
        @(negedge CLK);
        check("over_error", {31'd0, error}, 32'd1);
        check("over_sready", {31'd0, s_ready}, 32'd0);
        check("over_corerst", {31'd0, core_rst_n}, 32'd0);
        check("over_done", {31'd0, done}, 32'd0);
        check("over_no_writes", wr_cnt - base, 32'd0);
        pulse_start();

        // Two-word load with random bubbles
        base = wr_cnt;
        load_two(3, 8'h96);
        expect_two_done("bubble");
        pulse_start();

`ifdef LOADER_CHECKSUM_EN
        // Checksum mismatch, then correct reload
        base = wr_cnt;
        load_two(0, 8'h97);
        @(negedge CLK);
        check("csum_bad_error", {31'd0, error}, 32'd1);
        check("csum_bad_corerst", {31'd0, core_rst_n}, 32'd0);
        check("csum_bad_done", {31'd0, done}, 32'd0);
        pulse_start();
        base = wr_cnt;
        load_two(0, 8'h96);
        expect_two_done("csum_good");
        pulse_start();
`endif

        // Reset after 6 payload bytes, then reload
        base = wr_cnt;
        send(8'h02, 0);
        send(8'h00, 0);
        send(8'h13, 0);
        send(8'h00, 0);
        send(8'h50, 0);
        send(8'h00, 0);
        send(8'h93, 0);
        send(8'h00, 0);
        check("mid_first_write", wr_cnt - base, 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_corerst", {31'd0, core_rst_n}, 32'd0);
        check("mid_rst_we", {31'd0, imem_we}, 32'd0);
        check("mid_rst_addr", {22'd0, imem_addr}, 32'd0);
        check("mid_rst_wd", imem_wd, 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        rst = 1'b1;
        @(negedge CLK);
        base = wr_cnt;
        load_two(0, 8'h96);
        expect_two_done("reload");
        repeat (3) @(negedge CLK);
        check("reload_no_extra_writes", wr_cnt - base, 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
